rx_pkt_assembler: RTL

RX_PKT_ASSEMBLER -- requirements
Module: rx_pkt_assembler

---
 rtl/rx_pkt_if.sv | 24 ++
 rtl/rx_pkt_assembler.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rx_pkt_if.sv
// rx_pkt_if: byte-stream input from the FEC decoder plus the AXI-Stream
// output of the packet assembler. The slave modport is the assembler's view.
`timescale 1ns/1ps

interface rx_pkt_if;
    logic       ival;
    logic [7:0] idat;
    logic       ierr;
    logic       ordy;
    logic       m_tvalid;
    logic       m_tready;
    logic [7:0] m_tdata;
    logic       m_tlast;

    modport slave (
        input  ival, idat, ierr, m_tready,
        output ordy, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output ival, idat, ierr, m_tready,
        input  ordy, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/rx_pkt_assembler.sv
// rx_pkt_assembler: collects decoded bytes into fixed-length frames in a
// circular byte buffer and only releases whole, committed frames on an
// AXI-Stream output.
// Optional build macro RX_PKT_DROP_ON_ERR_EN: a frame whose last byte arrives
// with ierr=1 is rolled back instead of committed and counted in o_drop_cnt.
`timescale 1ns/1ps

module rx_pkt_assembler #(
    parameter int pFRAME_LEN = 256,
    parameter int pDEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst,
    rx_pkt_if.slave     bus,
    output logic        o_ovf,
    output logic [15:0] o_frm_cnt,
    output logic [15:0] o_drop_cnt
);

`ifdef RX_PKT_DROP_ON_ERR_EN
    localparam bit DROP_ON_ERR = 1'b1;
`else
    localparam bit DROP_ON_ERR = 1'b0;
`endif

    localparam int AW = $clog2(pDEPTH);
    localparam int PW = AW + 1;
    localparam int CW = (pFRAME_LEN > 2) ? $clog2(pFRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(pFRAME_LEN - 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(pDEPTH);
    localparam logic [PW-1:0] ONE_P    = PW'(1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} rd_state_t;

    logic [7:0]    mem [pDEPTH];
    logic [PW-1:0] wr_ptr, wr_commit, rd_ptr;
    logic [PW-1:0] fill, wr_nxt, rd_nxt;
    logic [CW-1:0] wr_cnt, rd_cnt;
    logic          acc_p0, last_p0, drop_p0, hs;
    logic          rd_en;
    logic [7:0]    dat_p1;
    rd_state_t     state, state_nxt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable;
    // the byte sitting in the output register stays counted until handshake.
    assign fill     = wr_ptr - rd_ptr;
    assign wr_nxt   = wr_ptr + ONE_P;
    assign rd_nxt   = rd_ptr + ONE_P;
    assign bus.ordy = rst && (fill < DEPTH_P);
    assign acc_p0   = bus.ival && bus.ordy;
    assign last_p0  = acc_p0 && (wr_cnt == LAST_IDX);
    assign drop_p0  = last_p0 && DROP_ON_ERR && bus.ierr;
    assign hs       = (state == HOLD) && bus.m_tready;

    // Write side: advance the fill pointer, commit or roll back whole frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            wr_commit  <= '0;
            wr_cnt     <= '0;
            o_ovf      <= 1'b0;
            o_frm_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (bus.ival && !bus.ordy)
                o_ovf <= 1'b1;
            if (acc_p0) begin
                if (last_p0) begin
                    wr_cnt <= '0;
                    if (drop_p0) begin
                        wr_ptr     <= wr_commit;
                        o_drop_cnt <= o_drop_cnt + 16'd1;
                    end else begin
                        wr_ptr    <= wr_nxt;
                        wr_commit <= wr_nxt;
                        o_frm_cnt <= o_frm_cnt + 16'd1;
                    end
                end else begin
                    wr_ptr <= wr_nxt;
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end
        end
    end

    // Buffer RAM write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (acc_p0)
            mem[wr_ptr[AW-1:0]] <= bus.idat;
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Read FSM: fetch one committed byte, hold it until the consumer takes it.
    always_comb begin
        state_nxt    = state;
        rd_en        = 1'b0;
        bus.m_tvalid = 1'b0;
        bus.m_tdata  = 8'h00;
        bus.m_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (rd_ptr != wr_commit)
                    state_nxt = FETCH;
            end
            FETCH: begin
                rd_en     = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                bus.m_tvalid = 1'b1;
                bus.m_tdata  = dat_p1;
                bus.m_tlast  = (rd_cnt == LAST_IDX);
                if (bus.m_tready)
                    state_nxt = (rd_nxt != wr_commit) ? FETCH : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pointer and output byte position advance on each handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            rd_cnt <= '0;
        end else if (hs) begin
            rd_ptr <= rd_nxt;
            rd_cnt <= (rd_cnt == LAST_IDX) ? '0 : rd_cnt + CW'(1);
        end
    end

    // ---- stage p1: registered RAM read feeding the output ----
    always_ff @(posedge clk) begin
        if (rd_en)
            dat_p1 <= mem[rd_ptr[AW-1:0]];
    end

endmodule
